hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Next-generation hazard unit for the 4-bit-opcode pipeline. Replaces the fixed
//  single-cycle load-to-use compare with a per-register scoreboard (parametrised
//  load latency) and a branch-penalty FSM. Sits beside the ID stage. Drives the
//  stall that holds PC/IF-ID and injects a bubble into ID/EX.
// PARAMETERS
//  REG_AW      4  register address width; the scoreboard has 2**REG_AW entries
//  LOAD_LAT    1  cycles after load issue before its data can be forwarded to EX (>=1)
//  BR_PENALTY  2  bubble cycles after a B/BR issues (>=1)
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  id_valid    in   1       ID holds a valid instruction
//  id_opcode   in   4       ID opcode
//  id_rs       in   REG_AW  ID source register RS
//  id_rt       in   REG_AW  ID source register RT
//  id_rd       in   REG_AW  ID destination register (load target)
//  stall       out  1       hold PC and IF/ID; insert a bubble into ID/EX
//  br_busy     out  1       branch-penalty FSM is not IDLE
//  issue       out  1       id_valid & !stall: the instruction advances this cycle
// BEHAVIOUR
//  Opcodes: LD=4'b1000, ST=4'b1001, B=4'b1100, BR=4'b1101.
//   rt_used = (op[3:2]!=2'b11) & !(op[3:2]==2'b01 & op!=4'b0111).
//  Scoreboard: pend[r] is a down-counter of width $clog2(LOAD_LAT+1). Reset value 0.
//   - Each cycle, every nonzero pend[r] decrements by 1.
//   - If issue & op==LD, pend[id_rd] <= LOAD_LAT. This load overrides the decrement
//     for the same register in the same cycle.
//  Data hazard (combinational):
//   haz = id_valid & ( pend[id_rs]!=0
//         | (rt_used & op!=ST & pend[id_rt]!=0)
//         | (op==ST & pend[id_rt]>1) ).
//   ST data is consumed one stage later, so a ST only needs pend[rt]<=1.
//  Branch FSM. States IDLE and BR_WAIT. Counter bcnt, reset 0.
//   - IDLE -> BR_WAIT when issue & (op==B | op==BR); bcnt <= BR_PENALTY.
//   - BR_WAIT: bcnt decrements each cycle. Go to IDLE on the cycle bcnt reaches 1,
//     so BR_WAIT lasts exactly BR_PENALTY cycles.
//   - br_busy = (state==BR_WAIT).
//  Outputs:
//   stall = haz | br_busy.  issue = id_valid & !stall.
//   stall is combinational; there is no added latency.
//  A branch that issues while a load is pending behaves normally; both hazard
//   sources are ORed into stall.
//  id_valid=0: no issue, no scoreboard load. Counters and FSM still advance.
//  Reset: while rst=1, all pend=0, state=IDLE, bcnt=0. stall, br_busy and issue are
//   forced to 0. Reset mid-operation discards pending loads and the branch penalty.
//  Register 0 gets no special treatment.
// CONFIGURATION
//  HAZARD_CTRL_STATS_EN defined: adds output stall_cnt[31:0] (reset 0). It
//   increments on every cycle with stall=1 and saturates at 32'hFFFF_FFFF. It also
//   adds output br_cnt[15:0] (reset 0), which increments on each branch issue and
//   wraps.
//  HAZARD_CTRL_STATS_EN undefined: these ports and their counters do not exist.
//   The remaining behaviour is identical.
// TESTING
//  1 LOAD_LAT=1: issue LD r3, then ADD rs=r3 -> stall=1 for 1 cycle, then issue=1.
//  2 LOAD_LAT=3: LD r5, then ST rt=r5 -> stall 2 cycles; a consumer with rs=r5
//    instead -> stall 3 cycles.
//  3 LD r2 immediately followed by a shift op (op=4'b1110) with rt=r2 -> no stall,
//    since RT is unused.
//  4 BR_PENALTY=2: issue B -> br_busy=1 and stall=1 for exactly 2 cycles, then IDLE.
//    A new id_valid is held throughout.
//  5 LD r4 re-issued to r4 while pend[r4]=1 (LOAD_LAT=2) -> pend reloads to 2.
//    A consumer stalls 2 more cycles.
//  6 rst asserted with pend[r1]=2 and state=BR_WAIT -> next cycle stall=0,
//    br_busy=0, and a consumer of r1 issues immediately.
//    With STATS_EN, stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard unit beside ID: per-register load scoreboard plus branch-penalty FSM.
// Optional statistics counters are built when HAZARD_CTRL_STATS_EN is defined.
module hazard_ctrl #(
    parameter int REG_AW     = 4,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              stall,
    output logic              br_busy,
    output logic              issue
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       br_cnt
`endif
);

    localparam int NREG = 1 << REG_AW;
    localparam int PW   = $clog2(LOAD_LAT + 1);
    localparam int BW   = $clog2(BR_PENALTY + 1);

    localparam logic [3:0] OP_LD = 4'b1000;
    localparam logic [3:0] OP_ST = 4'b1001;
    localparam logic [3:0] OP_B  = 4'b1100;
    localparam logic [3:0] OP_BR = 4'b1101;

    typedef enum logic {
        S_IDLE,
        S_BR_WAIT
    } br_state_e;

    logic [PW-1:0] pend_q [NREG];
    logic [PW-1:0] pend_d [NREG];
    br_state_e     state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          br_busy_q, br_busy_d;

    logic rt_used, is_ld, is_st, is_br, haz;

    always_comb begin
        is_ld   = (id_opcode == OP_LD);
        is_st   = (id_opcode == OP_ST);
        is_br   = (id_opcode == OP_B) || (id_opcode == OP_BR);
        rt_used = (id_opcode[3:2] != 2'b11) &&
                  !((id_opcode[3:2] == 2'b01) && (id_opcode != 4'b0111));

        // A store reads RT one stage later, so it tolerates one remaining cycle.
        haz = id_valid && ((pend_q[id_rs] != '0) ||
                           (rt_used && !is_st && (pend_q[id_rt] != '0)) ||
                           (is_st && (int'(pend_q[id_rt]) > 1)));

        stall   = (haz || br_busy_q) && !rst;
        br_busy = br_busy_q && !rst;
        issue   = id_valid && !stall && !rst;
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - PW'(1) : '0;
        end
        if (issue && is_ld) begin
            pend_d[id_rd] = PW'(LOAD_LAT);
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            S_IDLE: begin
                if (issue && is_br) begin
                    state_d = S_BR_WAIT;
                    bcnt_d  = BW'(BR_PENALTY);
                end
            end
            S_BR_WAIT: begin
                if (bcnt_q == BW'(1)) begin
                    state_d = S_IDLE;
                    bcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt_q - BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                bcnt_d  = '0;
            end
        endcase
        br_busy_d = (state_d == S_BR_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
            state_q   <= S_IDLE;
            bcnt_q    <= '0;
            br_busy_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            br_busy_q <= br_busy_d;
        end
    end

`ifdef HAZARD_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] br_cnt_q, br_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        br_cnt_d = br_cnt_q;
        if (issue && is_br) begin
            br_cnt_d = br_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            br_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            br_cnt_q    <= br_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign br_cnt    = br_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Random-stimulus bench for hazard_ctrl: three configurations share one input
// stream, each checked against a ready-time model of its scoreboard and branch window.
module tb_hazard_ctrl;

    localparam int NDUT   = 3;
    localparam int NCYC   = 3000;
    localparam logic [3:0] OP_LD = 4'b1000;
    localparam logic [3:0] OP_ST = 4'b1001;
    localparam logic [3:0] OP_B  = 4'b1100;
    localparam logic [3:0] OP_BR = 4'b1101;

    function automatic int ll_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 2;
    endfunction

    function automatic int bp_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       id_valid = 1'b0;
    logic [3:0] id_opcode = 4'h0;
    logic [3:0] id_rs = 4'h0, id_rt = 4'h0, id_rd = 4'h0;

    logic stall_w [NDUT];
    logic busy_w  [NDUT];
    logic issue_w [NDUT];
`ifdef HAZARD_CTRL_STATS_EN
    logic [31:0] stall_cnt_w [NDUT];
    logic [15:0] br_cnt_w    [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        hazard_ctrl #(
            .REG_AW    (4),
            .LOAD_LAT  (ll_of(g)),
            .BR_PENALTY(bp_of(g))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .id_valid (id_valid),
            .id_opcode(id_opcode),
            .id_rs    (id_rs),
            .id_rt    (id_rt),
            .id_rd    (id_rd),
            .stall    (stall_w[g]),
            .br_busy  (busy_w[g]),
            .issue    (issue_w[g])
`ifdef HAZARD_CTRL_STATS_EN
            ,
            .stall_cnt(stall_cnt_w[g]),
            .br_cnt   (br_cnt_w[g])
`endif
        );
    end

    // scoreboard counters
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: cycle at which each register's load data becomes usable,
    // and the cycle at which the branch window closes.
    longint ready_at  [NDUT][16];
    longint busy_till [NDUT];
`ifdef HAZARD_CTRL_STATS_EN
    longint      m_stall_cnt [NDUT];
    logic [15:0] m_br_cnt    [NDUT];
`endif

    function automatic longint pend_of(input int i, input int r, input longint cyc);
        longint d;
        d = ready_at[i][r] - cyc;
        return (d > 0) ? d : 0;
    endfunction

    task automatic drive_random(input int cyc);
        rst      = (cyc < 2) || ($urandom_range(0, 99) < 2);
        id_valid = ($urandom_range(0, 9) != 0);
        case ($urandom_range(0, 9))
            0, 1:    id_opcode = OP_LD;
            2:       id_opcode = OP_ST;
            3:       id_opcode = OP_B;
            4:       id_opcode = OP_BR;
            5:       id_opcode = 4'b1110;
            6:       id_opcode = 4'b0111;
            7:       id_opcode = 4'b0101;
            default: id_opcode = 4'($urandom_range(0, 15));
        endcase
        id_rs = 4'($urandom_range(0, 3));
        id_rt = 4'($urandom_range(0, 3));
        id_rd = 4'($urandom_range(0, 3));
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            busy_till[i] = 0;
            for (int r = 0; r < 16; r++) ready_at[i][r] = 0;
`ifdef HAZARD_CTRL_STATS_EN
            m_stall_cnt[i] = 0;
            m_br_cnt[i]    = '0;
`endif
        end

        for (int c = 0; c < NCYC; c++) begin
            drive_random(c);
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                bit rt_used, is_st, is_br, haz, busy, e_stall, e_issue;
                longint pr, pt;
                is_st   = (id_opcode == OP_ST);
                is_br   = (id_opcode == OP_B) || (id_opcode == OP_BR);
                rt_used = (id_opcode[3:2] != 2'b11) &&
                          !((id_opcode[3:2] == 2'b01) && (id_opcode != 4'b0111));
                pr      = pend_of(i, int'(id_rs), c);
                pt      = pend_of(i, int'(id_rt), c);
                haz     = id_valid && ((pr != 0) || (rt_used && !is_st && pt != 0) ||
                                       (is_st && pt > 1));
                busy    = !rst && (c < busy_till[i]);
                e_stall = !rst && (haz || busy);
                e_issue = !rst && id_valid && !e_stall;

                check_val($sformatf("stall[%0d] c%0d", i, c), 32'(stall_w[i]), 32'(e_stall));
                check_val($sformatf("br_busy[%0d] c%0d", i, c), 32'(busy_w[i]), 32'(busy));
                check_val($sformatf("issue[%0d] c%0d", i, c), 32'(issue_w[i]), 32'(e_issue));
`ifdef HAZARD_CTRL_STATS_EN
                if (c > 0) begin
                    check_val($sformatf("stall_cnt[%0d] c%0d", i, c), stall_cnt_w[i],
                              32'(m_stall_cnt[i]));
                    check_val($sformatf("br_cnt[%0d] c%0d", i, c), 32'(br_cnt_w[i]),
                              32'(m_br_cnt[i]));
                end
`endif
                if (rst) begin
                    busy_till[i] = 0;
                    for (int r = 0; r < 16; r++) ready_at[i][r] = 0;
`ifdef HAZARD_CTRL_STATS_EN
                    m_stall_cnt[i] = 0;
                    m_br_cnt[i]    = '0;
`endif
                end else begin
                    if (e_issue && id_opcode == OP_LD)
                        ready_at[i][int'(id_rd)] = c + 1 + ll_of(i);
                    if (e_issue && is_br)
                        busy_till[i] = c + 1 + bp_of(i);
`ifdef HAZARD_CTRL_STATS_EN
                    if (e_stall && m_stall_cnt[i] < 64'hFFFF_FFFF) m_stall_cnt[i]++;
                    if (e_issue && is_br) m_br_cnt[i] = m_br_cnt[i] + 16'd1;
`endif
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
